// File: rtl/led_disp_pkg.sv
// Shared types and constants for the multiplexed seven-segment scan driver.
`ifndef LED_DIGIT_SLICE
`define LED_DIGIT_SLICE(bus, k) bus[7*(k) +: 7]
`endif

package led_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_ON    = 2'd2
  } scan_state_e;

  // Wide enough for the largest digit count; callers slice to NUM_DIGITS.
  localparam logic [15:0] ENB_OFF = 16'hFFFF;
  localparam logic [6:0]  SEG_OFF = 7'b0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_scan_disp_if.sv
// Decoder-side inputs and board-side outputs of the scan driver.
interface led_scan_disp_if #(
  parameter int NUM_DIGITS = 6,
  parameter int BRIGHT_W   = 4,
  parameter int IDX_W      = led_disp_pkg::idx_width(NUM_DIGITS)
);
  logic                    i_en;
  logic [7*NUM_DIGITS-1:0] i_digit_seg;
  logic [NUM_DIGITS-1:0]   i_dp;
  logic [NUM_DIGITS-1:0]   i_blank_mask;
  logic [NUM_DIGITS-1:0]   i_blink_mask;
  logic [BRIGHT_W-1:0]     i_bright;
  logic [6:0]              o_seg;
  logic                    o_seg_dp;
  logic [NUM_DIGITS-1:0]   o_seg_enb;
  logic [IDX_W-1:0]        o_digit_idx;
  logic                    o_frame_done;

  modport master (
    output i_en, i_digit_seg, i_dp, i_blank_mask, i_blink_mask, i_bright,
    input  o_seg, o_seg_dp, o_seg_enb, o_digit_idx, o_frame_done
  );

  modport slave (
    input  i_en, i_digit_seg, i_dp, i_blank_mask, i_blink_mask, i_bright,
    output o_seg, o_seg_dp, o_seg_enb, o_digit_idx, o_frame_done
  );
endinterface

// File: rtl/led_scan_timer.sv
// Slot timer: slot counter, digit index wrap, blank/on phase and frame end.
// IDLE = scan stopped | BLANK = dead time at slot start | ON = digit may be lit
module led_scan_timer import led_disp_pkg::*; #(
  parameter int NUM_DIGITS = 6,
  parameter int SCAN_DIV   = 5000,
  parameter int BLANK_CYC  = 64,
  parameter int IDX_W      = idx_width(NUM_DIGITS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output scan_state_e      o_state,
  output logic             o_slot_start,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_frame_done
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ON   = CNT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  scan_state_e      state_q, state_d;
  logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             slot_wrap;

  assign slot_wrap = (state_q != ST_IDLE) && (slot_cnt_q == CNT_LAST);

  always_comb begin
    state_d    = state_q;
    slot_cnt_d = slot_cnt_q;
    idx_d      = idx_q;
    if (!i_en) begin
      state_d    = ST_IDLE;
      slot_cnt_d = '0;
      idx_d      = '0;
    end else if (state_q == ST_IDLE) begin
      state_d    = ST_BLANK;
      slot_cnt_d = '0;
      idx_d      = '0;
    end else begin
      slot_cnt_d = slot_wrap ? '0 : slot_cnt_q + 1'b1;
      if (slot_wrap) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      state_d = (slot_cnt_d < CNT_ON) ? ST_BLANK : ST_ON;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      slot_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      slot_cnt_q <= slot_cnt_d;
      idx_q      <= idx_d;
    end
  end

  assign o_state      = state_q;
  assign o_idx        = idx_q;
  assign o_slot_start = (state_q != ST_IDLE) && (slot_cnt_q == '0);
  assign o_frame_done = slot_wrap && (idx_q == IDX_LAST);

endmodule

// File: rtl/led_scan_disp.sv
// Multiplexed seven-segment scan driver: per-slot input latch, PWM dimming,
// blink phase and registered pin outputs around the slot timer.
module led_scan_disp import led_disp_pkg::*; #(
  parameter int NUM_DIGITS   = 6,
  parameter int SCAN_DIV     = 5000,
  parameter int BLANK_CYC    = 64,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64,
  parameter int IDX_W        = idx_width(NUM_DIGITS)
) (
  input logic             clk,
  input logic             rst_n,
  led_scan_disp_if.slave  bus
);

  localparam int FC_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FC_W-1:0]       FC_LAST     = FC_W'(BLINK_FRAMES - 1);
  localparam logic [NUM_DIGITS-1:0] ENB_ALL_OFF = ENB_OFF[NUM_DIGITS-1:0];

  scan_state_e      state;
  logic             slot_start;
  logic             frame_done_c;
  logic [IDX_W-1:0] idx;

  led_scan_timer #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV),
    .BLANK_CYC  (BLANK_CYC),
    .IDX_W      (IDX_W)
  ) u_timer (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_en         (bus.i_en),
    .o_state      (state),
    .o_slot_start (slot_start),
    .o_idx        (idx),
    .o_frame_done (frame_done_c)
  );

  logic [6:0]            seg_lat_q, seg_lat_d;
  logic                  dp_lat_q, dp_lat_d;
  logic                  blank_lat_q, blank_lat_d;
  logic                  blink_lat_q, blink_lat_d;
  logic [BRIGHT_W-1:0]   bright_lat_q, bright_lat_d;
  logic [BRIGHT_W-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                  blink_phase_q, blink_phase_d;
  logic [6:0]            seg_q, seg_d;
  logic                  seg_dp_q, seg_dp_d;
  logic [NUM_DIGITS-1:0] seg_enb_q, seg_enb_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic                  frame_done_q, frame_done_d;
  logic                  lit;

  always_comb begin
    seg_lat_d    = seg_lat_q;
    dp_lat_d     = dp_lat_q;
    blank_lat_d  = blank_lat_q;
    blink_lat_d  = blink_lat_q;
    bright_lat_d = bright_lat_q;
    if (slot_start) begin
      seg_lat_d    = `LED_DIGIT_SLICE(bus.i_digit_seg, idx);
      dp_lat_d     = bus.i_dp[idx];
      blank_lat_d  = bus.i_blank_mask[idx];
      blink_lat_d  = bus.i_blink_mask[idx];
      bright_lat_d = bus.i_bright;
    end

    // Held at zero outside ON so every slot starts its PWM period at zero.
    pwm_cnt_d = (state == ST_ON) ? pwm_cnt_q + 1'b1 : '0;

    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (!bus.i_en) begin
      frame_cnt_d = '0;
    end else if (frame_done_c) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end

    lit = (state == ST_ON) && (pwm_cnt_q <= bright_lat_q) && !blank_lat_q &&
          !(blink_lat_q && blink_phase_q);

    seg_enb_d    = ENB_ALL_OFF;
    seg_d        = SEG_OFF;
    seg_dp_d     = 1'b0;
    digit_idx_d  = '0;
    frame_done_d = 1'b0;
    if (bus.i_en) begin
      digit_idx_d  = idx;
      frame_done_d = frame_done_c;
      if (lit) begin
        seg_enb_d[idx] = 1'b0;
        seg_d          = seg_lat_q;
        seg_dp_d       = dp_lat_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_lat_q     <= SEG_OFF;
      dp_lat_q      <= 1'b0;
      blank_lat_q   <= 1'b0;
      blink_lat_q   <= 1'b0;
      bright_lat_q  <= '0;
      pwm_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      seg_q         <= SEG_OFF;
      seg_dp_q      <= 1'b0;
      seg_enb_q     <= ENB_ALL_OFF;
      digit_idx_q   <= '0;
      frame_done_q  <= 1'b0;
    end else begin
      seg_lat_q     <= seg_lat_d;
      dp_lat_q      <= dp_lat_d;
      blank_lat_q   <= blank_lat_d;
      blink_lat_q   <= blink_lat_d;
      bright_lat_q  <= bright_lat_d;
      pwm_cnt_q     <= pwm_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
      seg_enb_q     <= seg_enb_d;
      digit_idx_q   <= digit_idx_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.o_seg        = seg_q;
  assign bus.o_seg_dp     = seg_dp_q;
  assign bus.o_seg_enb    = seg_enb_q;
  assign bus.o_digit_idx  = digit_idx_q;
  assign bus.o_frame_done = frame_done_q;

endmodule

// File: tb/tb_led_scan_disp.sv
// Directed bench for led_scan_disp: per-slot expectations queued at stimulus
// time and compared against what the pins show during that slot.
module tb_led_scan_disp;

  localparam int ND = 4, SD = 40, BC = 4, BW = 2, BF = 2, IW = 2;
  localparam int ON_CYC = SD - BC;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  led_scan_disp_if #(.NUM_DIGITS(ND), .BRIGHT_W(BW), .IDX_W(IW)) bus ();

  led_scan_disp #(
    .NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC), .BRIGHT_W(BW),
    .BLINK_FRAMES(BF), .IDX_W(IW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    int idx;
    int seg;
    int dp;
    int low;
    int fd;
  } slot_exp_t;

  slot_exp_t  sb[$];
  int         n_assert = 0;
  int         n_fail = 0;
  int         m_idx, m_fc, m_ph;
  logic [6:0] pat[ND];

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_enb"}, int'(bus.o_seg_enb), 15);
    chk({tag, "_seg"}, int'(bus.o_seg), 0);
    chk({tag, "_dp"},  int'(bus.o_seg_dp), 0);
    chk({tag, "_idx"}, int'(bus.o_digit_idx), 0);
    chk({tag, "_fd"},  int'(bus.o_frame_done), 0);
  endtask

  // Expected pin behaviour of the next slot, from the inputs as they stand now.
  task automatic push_slot();
    slot_exp_t e;
    int dark;
    e.idx = m_idx;
    e.seg = int'(pat[m_idx]);
    e.dp  = int'(bus.i_dp[m_idx]);
    dark  = int'(bus.i_blank_mask[m_idx]) | (int'(bus.i_blink_mask[m_idx]) & m_ph);
    e.low = dark ? 0 : (ON_CYC / (1 << BW)) * (int'(bus.i_bright) + 1);
    e.fd  = (m_idx == ND - 1) ? 1 : 0;
    sb.push_back(e);
    if (m_idx == ND - 1) begin
      if (m_fc == BF - 1) begin
        m_fc = 0;
        m_ph = 1 - m_ph;
      end else begin
        m_fc++;
      end
    end
    m_idx = (m_idx + 1) % ND;
  endtask

  task automatic run_slot(input int chg_at, input int chg_br);
    slot_exp_t  e;
    logic [3:0] lit_pat;
    int idx_err = 0, dead_err = 0, shape_err = 0, low = 0, fd_cnt = 0, fd_last = 0;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL sb_empty: observed 0 queued expected 1");
      return;
    end
    e = sb.pop_front();
    lit_pat = 4'hF;
    lit_pat[e.idx] = 1'b0;
    for (int j = 0; j < SD; j++) begin
      @(negedge clk);
      if (int'(bus.o_digit_idx) != e.idx) idx_err++;
      if (j < BC && bus.o_seg_enb !== 4'hF) dead_err++;
      if (bus.o_seg_enb === lit_pat) begin
        low++;
        if (bus.o_seg !== 7'(e.seg) || bus.o_seg_dp !== 1'(e.dp)) shape_err++;
      end else if (bus.o_seg_enb !== 4'hF || bus.o_seg !== 7'h0 || bus.o_seg_dp !== 1'b0) begin
        shape_err++;
      end
      if (bus.o_frame_done === 1'b1) begin
        fd_cnt++;
        if (j == SD - 1) fd_last = 1;
      end
      if (j == chg_at) bus.i_bright = chg_br[BW-1:0];
    end
    chk($sformatf("d%0d_idx_errs", e.idx), idx_err, 0);
    chk($sformatf("d%0d_dead_errs", e.idx), dead_err, 0);
    chk($sformatf("d%0d_shape_errs", e.idx), shape_err, 0);
    chk($sformatf("d%0d_low_cycles", e.idx), low, e.low);
    chk($sformatf("d%0d_fd_count", e.idx), fd_cnt, e.fd);
    chk($sformatf("d%0d_fd_last", e.idx), fd_last, e.fd);
  endtask

  task automatic run_slots(input int n);
    for (int k = 0; k < n; k++) begin
      push_slot();
      run_slot(-1, 0);
    end
  endtask

  initial begin
    int idle_err;
    bus.i_en = 1'b0;
    bus.i_digit_seg = '0;
    bus.i_dp = '0;
    bus.i_blank_mask = '0;
    bus.i_blink_mask = '0;
    bus.i_bright = '0;
    pat[0] = 7'h7E; pat[1] = 7'h30; pat[2] = 7'h6D; pat[3] = 7'h79;
    m_idx = 0; m_fc = 0; m_ph = 0;

    // Reset, then idle with scan disabled
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    idle_err = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.o_seg_enb !== 4'hF || bus.o_seg !== 7'h0 || bus.o_frame_done !== 1'b0) idle_err++;
    end
    chk("idle_errs", idle_err, 0);

    // Scan order at full brightness, two frames
    bus.i_digit_seg = {pat[3], pat[2], pat[1], pat[0]};
    bus.i_dp = 4'b1010;
    bus.i_bright = 2'd3;
    bus.i_en = 1'b1;
    @(negedge clk);
    chk("en_first_enb", int'(bus.o_seg_enb), 15);
    run_slots(8);

    // Brightness codes, then a mid-slot change
    bus.i_bright = 2'd1;
    run_slots(4);
    bus.i_bright = 2'd0;
    run_slots(4);
    push_slot();
    run_slot(20, 3);
    run_slots(1);

    // Blanked digit 2
    bus.i_blank_mask = 4'b0100;
    run_slots(4);
    bus.i_blank_mask = 4'b0000;

    // Blink on digit 0 from a fresh reset: lit, dark, lit in frame pairs
    rst_n = 1'b0;
    bus.i_en = 1'b0;
    @(negedge clk);
    bus.i_blink_mask = 4'b0001;
    bus.i_bright = 2'd3;
    m_idx = 0; m_fc = 0; m_ph = 0;
    rst_n = 1'b1;
    bus.i_en = 1'b1;
    @(negedge clk);
    run_slots(24);
    bus.i_blink_mask = 4'b0000;

    // Drop enable at slot_cnt 20 of digit 2
    run_slots(2);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 10) chk("pre_abort_enb", int'(bus.o_seg_enb), 4'b1011);
    end
    bus.i_en = 1'b0;
    @(negedge clk);
    chk_reset_outputs("en_drop");
    m_idx = 0; m_fc = 0;
    bus.i_en = 1'b1;
    @(negedge clk);
    chk("reen_enb", int'(bus.o_seg_enb), 15);
    run_slots(2);

    // Asynchronous reset pulse in the middle of digit 2's ON phase
    for (int j = 0; j < 10; j++) @(negedge clk);
    chk("pre_rst_enb", int'(bus.o_seg_enb), 4'b1011);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    m_idx = 0; m_fc = 0; m_ph = 0;
    @(negedge clk);
    chk("post_rst_idx", int'(bus.o_digit_idx), 0);
    run_slots(4);

    chk("sb_leftover", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
